// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    D_REFILL = 2'd1,
    I_REFILL = 2'd2,
    REPLAY   = 2'd3
  } hz_state_t;

  localparam int unsigned XZR = 31;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage core: cache-miss refill handshake,
// load-use bubbles, taken-branch flushes and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned REFILL_TIMEOUT = 255,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned XZR            = pipe_ctrl_pkg::XZR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_hit,
  input  logic             dmem_req,
  input  logic             dmem_hit,
  input  logic             refill_done,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             refill_req,
  output logic             refill_is_data,
  output logic             refill_err,
  output logic [CNT_W-1:0] stall_cycles
);
  import pipe_ctrl_pkg::hz_state_t;
  import pipe_ctrl_pkg::RUN;
  import pipe_ctrl_pkg::D_REFILL;
  import pipe_ctrl_pkg::I_REFILL;
  import pipe_ctrl_pkg::REPLAY;

  localparam int unsigned WAIT_W = $clog2(REFILL_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_refill, timeout, dmiss, load_use;

  assign dmiss     = dmem_req & ~dmem_hit;
  assign load_use  = idex_mem_read && (idex_rd != 5'(XZR)) &&
                     ((idex_rd == ifid_rn) || (idex_rd == ifid_rm));
  assign in_refill = (state_q == D_REFILL) || (state_q == I_REFILL);
  // wait_cnt holds the number of completed refill cycles, so the last allowed one is TIMEOUT-1
  assign timeout   = in_refill && !refill_done &&
                     ((32'(wait_cnt) + 32'd1) == REFILL_TIMEOUT);
  assign err_d     = err_q | timeout;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (!in_refill),
    .en_i   (in_refill),
    .cnt_o  (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (1'b0),
    .en_i   (!pc_en),
    .cnt_o  (stall_cycles)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dmiss)                           state_d = D_REFILL;
        else if (!branch_taken && !imem_hit) state_d = I_REFILL;
      end
      D_REFILL: begin
        if (refill_done)  state_d = REPLAY;
        else if (timeout) state_d = RUN;
      end
      I_REFILL: if (refill_done || timeout) state_d = RUN;
      REPLAY:   state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Reset forces the pass-through pattern regardless of live inputs.
  always_comb begin
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    memwb_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    refill_req     = 1'b0;
    refill_is_data = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (dmiss) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          end else if (branch_taken) begin
            {ifid_flush, idex_flush, exmem_flush} = '1;
          end else if (!imem_hit || load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        D_REFILL: begin
          refill_req     = 1'b1;
          refill_is_data = 1'b1;
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end
        I_REFILL: begin
          refill_req = 1'b1;
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (dmiss) {idex_en, exmem_en, memwb_en} = '0;
        end
        REPLAY: {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        default: ;
      endcase
    end
  end

  assign refill_err = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural model,
// a negedge monitor pops and compares against the DUT.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO   = 8;
  localparam int unsigned CW   = 6;
  localparam int unsigned SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_hit = 1'b1, dmem_req = 1'b0, dmem_hit = 1'b1, refill_done = 1'b0;
  logic          idex_mem_read = 1'b0, branch_taken = 1'b0;
  logic [4:0]    idex_rd = '0, ifid_rn = '0, ifid_rm = '0;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush;
  logic          refill_req, refill_is_data, refill_err;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.REFILL_TIMEOUT(TO), .CNT_W(CW), .XZR(31)) dut (
    .clk(clk), .rst_n(rst_n), .imem_hit(imem_hit), .dmem_req(dmem_req),
    .dmem_hit(dmem_hit), .refill_done(refill_done), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm),
    .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .refill_req(refill_req), .refill_is_data(refill_is_data),
    .refill_err(refill_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    en;   // pc, ifid, idex, exmem, memwb
    logic [2:0]    fl;   // ifid, idex, exmem
    logic          req, isdat, err;
    logic [CW-1:0] stall;
  } exp_t;

  typedef struct packed {
    logic       rst, ih, dreq, dhit, done, mr;
    logic [4:0] rd, rn, rm;
    logic       br;
  } in_t;

  localparam in_t IDLE = '{rst:1'b1, ih:1'b1, dreq:1'b0, dhit:1'b1, done:1'b0,
                           mr:1'b0, rd:5'd0, rn:5'd1, rm:5'd2, br:1'b0};

  exp_t        q[$];
  int unsigned n_vec = 0, n_bad = 0;

  // Reference model: an outstanding refill (data or instruction), a pending replay slot.
  bit          m_busy, m_data, m_replay, m_err;
  int unsigned m_wait, m_stall;
  bit          last_pc_en = 1'b1;

  function automatic exp_t model_out();
    exp_t e;
    bit   dmiss, lu;
    dmiss   = dmem_req && !dmem_hit;
    lu      = idex_mem_read && (idex_rd != 5'd31) &&
              ((idex_rd == ifid_rn) || (idex_rd == ifid_rm));
    e.en    = '1;
    e.fl    = '0;
    e.req   = 1'b0;
    e.isdat = 1'b0;
    e.err   = m_err;
    e.stall = CW'(m_stall);
    if (!rst_n) return e;
    if (m_replay) e.en = '0;
    else if (m_busy) begin
      e.req   = 1'b1;
      e.isdat = m_data;
      if (m_data) e.en = '0;
      else begin
        e.en[4:3] = 2'b00;
        e.fl[1]   = 1'b1;
        if (dmiss) e.en[2:0] = 3'b000;
      end
    end
    else if (dmiss)        e.en = '0;
    else if (branch_taken) e.fl = '1;
    else if (!imem_hit || lu) begin
      e.en[4:3] = 2'b00;
      e.fl[1]   = 1'b1;
    end
    return e;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_data = 0; m_replay = 0; m_err = 0; m_wait = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    bit dmiss;
    dmiss = dmem_req && !dmem_hit;
    if (!last_pc_en && m_stall < SMAX) m_stall++;
    if (m_busy) begin
      m_wait++;
      if (refill_done) begin
        m_busy   = 0;
        m_replay = m_data;
      end else if (m_wait == TO) begin
        m_busy = 0;
        m_err  = 1;
      end
    end
    else if (m_replay) m_replay = 0;
    else if (dmiss) begin
      m_busy = 1; m_data = 1; m_wait = 0;
    end
    else if (!branch_taken && !imem_hit) begin
      m_busy = 1; m_data = 0; m_wait = 0;
    end
  endtask

  task automatic drive(input in_t v);
    exp_t e;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    rst_n = v.rst; imem_hit = v.ih; dmem_req = v.dreq; dmem_hit = v.dhit;
    refill_done = v.done; idex_mem_read = v.mr; idex_rd = v.rd;
    ifid_rn = v.rn; ifid_rm = v.rm; branch_taken = v.br;
    if (!v.rst) model_clear();
    e = model_out();
    last_pc_en = e.en[4];
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== e.en) begin
          n_bad++;
          $display("FAIL enables t=%0t got %b want %b", $time,
                   {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
        end
        if ({ifid_flush, idex_flush, exmem_flush} !== e.fl) begin
          n_bad++;
          $display("FAIL flushes t=%0t got %b want %b", $time,
                   {ifid_flush, idex_flush, exmem_flush}, e.fl);
        end
        if ({refill_req, refill_is_data, refill_err} !== {e.req, e.isdat, e.err}) begin
          n_bad++;
          $display("FAIL refill req/data/err t=%0t got %b want %b", $time,
                   {refill_req, refill_is_data, refill_err}, {e.req, e.isdat, e.err});
        end
        if (stall_cycles !== e.stall) begin
          n_bad++;
          $display("FAIL stall_cycles t=%0t got %0d want %0d", $time, stall_cycles, e.stall);
        end
      end
    end
  end

  initial begin : stimulus
    in_t        v;
    logic [4:0] regs [3];
    regs[0] = 5'd5; regs[1] = 5'd6; regs[2] = 5'd31;
    model_clear();

    // Reset, with a data miss presented on the inputs.
    v = IDLE; v.rst = 0; v.dreq = 1; v.dhit = 0; drive(v); drive(v);
    v = IDLE; repeat (2) drive(v);

    // Load-use on rn, then the XZR case which must not stall.
    v = IDLE; v.mr = 1; v.rd = 5; v.rn = 5; drive(v);
    v = IDLE; repeat (2) drive(v);
    v = IDLE; v.mr = 1; v.rd = 31; v.rn = 31; v.rm = 31; drive(v);
    v = IDLE; v.mr = 1; v.rd = 6; v.rm = 6; drive(v);
    v = IDLE; drive(v);

    // Data miss, refill_done on the 4th refill cycle, then replay.
    v = IDLE; v.dreq = 1; v.dhit = 0; drive(v);
    for (int i = 1; i <= 4; i++) begin
      v = IDLE; v.dreq = 1; v.dhit = 0; v.done = (i == 4); drive(v);
    end
    v = IDLE; v.dreq = 1; drive(v);
    v = IDLE; repeat (2) drive(v);

    // Data miss concurrent with a taken branch that stays in MEM.
    v = IDLE; v.dreq = 1; v.dhit = 0; v.br = 1; drive(v);
    v.done = 1; v.ih = 0; drive(v);
    v = IDLE; v.br = 1; v.dreq = 1; drive(v);
    drive(v);
    v = IDLE; drive(v);

    // Instruction miss, load miss arriving two cycles into the drain.
    v = IDLE; v.ih = 0; drive(v);
    for (int i = 1; i <= 4; i++) begin
      v = IDLE; v.ih = 0; v.dreq = (i >= 3); v.dhit = (i < 3); v.done = (i == 4); drive(v);
    end
    v = IDLE; v.dreq = 1; v.dhit = 0; drive(v);
    v.done = 1; drive(v);
    v = IDLE; repeat (2) drive(v);

    // refill_done coincides with the would-be timeout cycle: no error.
    v = IDLE; v.dreq = 1; v.dhit = 0; drive(v);
    for (int i = 1; i <= TO; i++) begin
      v = IDLE; v.done = (i == TO); drive(v);
    end
    v = IDLE; repeat (2) drive(v);

    // Timeout with no refill_done; error is sticky afterwards.
    v = IDLE; v.dreq = 1; v.dhit = 0; drive(v);
    v = IDLE; repeat (TO + 4) drive(v);
    v = IDLE; v.done = 1; drive(v);
    v = IDLE; v.ih = 0; drive(v);
    v = IDLE; v.done = 1; drive(v);
    v = IDLE; repeat (2) drive(v);

    // Asynchronous reset in the middle of a data refill.
    v = IDLE; v.dreq = 1; v.dhit = 0; drive(v); drive(v); drive(v);
    v.rst = 0; drive(v); drive(v);
    v = IDLE; repeat (2) drive(v);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      v.rst  = ($urandom_range(199) != 0);
      v.ih   = ($urandom_range(9) != 0);
      v.dreq = 1'($urandom_range(1));
      v.dhit = ($urandom_range(7) != 0);
      v.done = ($urandom_range(3) == 0);
      v.mr   = 1'($urandom_range(1));
      v.rd   = regs[$urandom_range(2)];
      v.rn   = regs[$urandom_range(2)];
      v.rm   = regs[$urandom_range(2)];
      v.br   = ($urandom_range(7) == 0);
      drive(v);
    end

    // Long instruction-miss storm drives stall_cycles into saturation.
    v = IDLE; v.rst = 0; drive(v);
    v = IDLE; v.ih = 0; repeat (100) drive(v);
    v = IDLE; repeat (3) drive(v);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
